pbit_update: RTL

- Stochastic p-bit update stage, directly downstream of the weighted-sum MAC.
- Consumes the MAC's signed, scaled, saturated input current I_i and produces the p-bit state m_i = (tanh(I_i) >= r), where r is a pseudo-random sample from an internal LFSR.
- The registered p_out feeds back to neighbouring MACs' p_in.
- Supports clamping, so adder terminals can be pinned in invertible mode.

---
 rtl/pbit_pkg.sv | 43 ++++
 rtl/pbit_lfsr.sv | 43 ++++
 rtl/pbit_update.sv | 107 ++++++++++
 3 files changed

// File: rtl/pbit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pbit_pkg
// Description : Shared constants for the p-bit datapath. Holds the tanh
//               lookup table, the LFSR width and tap mask, and a helper that
//               computes one LFSR step. The MAC and scheduler use it too.
// Revision    : 1.0 - initial release
// ============================================================================
package pbit_pkg;

  localparam int TANH_W    = 8;
  localparam int LUT_DEPTH = 64;
  localparam int LFSR_W    = 16;

  // Taps for x^16 + x^14 + x^13 + x^11 + 1 in a right-shifting Fibonacci
  // register. The exponents map to state bits 0, 2, 3 and 5.
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

  // round(127 * tanh(k/4)). The table is addressed by the raw two's
  // complement bits of k: entries 0..31 hold k = 0..31, and entries
  // 32..63 hold k = -32..-1.
  localparam logic signed [TANH_W-1:0] TANH_LUT [LUT_DEPTH] = '{
    // k = 0 .. 15
    8'sd0,    8'sd31,   8'sd59,   8'sd81,   8'sd97,   8'sd108,  8'sd115,  8'sd120,
    8'sd122,  8'sd124,  8'sd125,  8'sd126,  8'sd126,  8'sd127,  8'sd127,  8'sd127,
    // k = 16 .. 31
    8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,
    8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,  8'sd127,
    // k = -32 .. -17
    -8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd127,
    -8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd127,
    // k = -16 .. -1
    -8'sd127, -8'sd127, -8'sd127, -8'sd127, -8'sd126, -8'sd126, -8'sd125, -8'sd124,
    -8'sd122, -8'sd120, -8'sd115, -8'sd108, -8'sd97,  -8'sd81,  -8'sd59,  -8'sd31
  };

  // One LFSR step: the XOR of the tapped bits enters at the MSB.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pbit_lfsr.sv
`default_nettype none
// ============================================================================
// Module      : pbit_lfsr
// Description : Free-running 16-bit Fibonacci LFSR. It reloads SEED if the
//               state ever becomes zero. The low OUT_W bits of the state are
//               presented in parallel as the random sample.
// Revision    : 1.0 - initial release
// ============================================================================
module pbit_lfsr
  import pbit_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1,
  parameter int                OUT_W = LFSR_W
) (
  input  logic             clk,
  input  logic             rst,
  output logic [OUT_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q;
  logic [LFSR_W-1:0] state_d;

  // Next state; the all-zero state is a lock-up, so escape it via SEED.
  always_comb begin
    state_d = lfsr_step(state_q);
    if (state_q == '0) begin
      state_d = SEED;
    end
  end

  // State register, advances every cycle out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q[OUT_W-1:0];

endmodule
`default_nettype wire

// File: rtl/pbit_update.sv
`default_nettype none
// ============================================================================
// Module      : pbit_update
// Description : Stochastic p-bit update stage. An update request samples the
//               input current and a random value r. Two cycles later p_out
//               becomes (tanh(I) >= r). A clamp overrides p_out with a fixed
//               value, so terminals can be pinned.
// Revision    : 1.0 - initial release
// ============================================================================
module pbit_update
  import pbit_pkg::*;
#(
  parameter int                IN_PRECISION = 6,
  parameter logic [LFSR_W-1:0] SEED         = 16'hACE1,
  parameter logic              P_INIT       = 1'b0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic signed [IN_PRECISION-1:0] i_in,
  input  logic                           upd_valid,
  input  logic                           clamp_en,
  input  logic                           clamp_val,
  output logic                           p_out,
  output logic                           upd_done
);

  // Current random sample: the low byte of the LFSR, read as signed.
  logic [TANH_W-1:0] r_cur;

  pbit_lfsr #(
    .SEED  (SEED),
    .OUT_W (TANH_W)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .state_o (r_cur)
  );

  // Stage 0 registers: the LUT address (raw bits of i_in) and r.
  logic                     v1_q;
  logic [IN_PRECISION-1:0]  idx_q;
  logic signed [TANH_W-1:0] r1_q;

  // Stage 1 registers: the looked-up tanh value and the r that travels with it.
  logic                     v2_q;
  logic signed [TANH_W-1:0] t_q;
  logic signed [TANH_W-1:0] r2_q;

  // Stage 2 next state.
  logic p_d;
  logic done_d;

  // Stage 0: capture the request together with this cycle's random sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q  <= 1'b0;
      idx_q <= '0;
      r1_q  <= '0;
    end else begin
      v1_q <= upd_valid;
      if (upd_valid) begin
        idx_q <= i_in;
        r1_q  <= r_cur;
      end
    end
  end

  // Stage 1: ROM read of the tanh table.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q <= 1'b0;
      t_q  <= '0;
      r2_q <= '0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        t_q  <= TANH_LUT[idx_q];
        r2_q <= r1_q;
      end
    end
  end

  // Stage 2 decision. The clamp wins over any arriving result. A discarded
  // result still reports done, so the downstream update count stays exact.
  always_comb begin
    p_d    = p_out;
    done_d = v2_q;
    if (clamp_en) begin
      p_d = clamp_val;
    end else if (v2_q) begin
      p_d = (t_q >= r2_q);
    end
  end

  // Stage 2 output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_out    <= P_INIT;
      upd_done <= 1'b0;
    end else begin
      p_out    <= p_d;
      upd_done <= done_d;
    end
  end

endmodule
`default_nettype wire
